// File: rtl/fanout_repeater_tree.sv
// fanout_repeater_tree: pipelined, registered fanout tree. One WIDTH-bit word
// is replicated onto NUM_OUT channels through levels of registers in which no
// node feeds more than MAX_FANOUT children. The final level applies a
// per-channel inversion and a per-channel update enable.
//
// Valid semantics: in_valid marks in_data as a word on a rising edge where
// stall=0. Each level carries one valid bit that follows the word down the
// tree. There is no ready: stall=1 freezes every register and ignores the
// inputs, so upstream must keep presenting the word until stall drops.
module fanout_repeater_tree #(
    parameter int                 WIDTH      = 1,
    parameter int                 NUM_OUT    = 20,
    parameter int                 MAX_FANOUT = 4,
    parameter logic [NUM_OUT-1:0] INV_MASK   = {NUM_OUT{1'b1}}
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    input  logic [WIDTH-1:0]           in_data,
    input  logic                       stall,
    input  logic [NUM_OUT-1:0]         chan_en,
    output logic                       out_valid,
    output logic [NUM_OUT*WIDTH-1:0]   out_data,
    output logic                       busy
);

    // Smallest level count whose fanout reach covers every channel (min 1).
    function automatic int calc_levels(input int n, input int mf);
        int lv;
        int reach;
        lv    = 1;
        reach = mf;
        for (int k = 0; k < 31; k++) begin
            if (reach < n) begin
                reach = reach * mf;
                lv++;
            end
        end
        return lv;
    endfunction

    localparam int LEVELS = calc_levels(NUM_OUT, MAX_FANOUT);

    // Node count of level lvl: ceil(NUM_OUT / MAX_FANOUT^(LEVELS-lvl)).
    function automatic int nodes_at(input int lvl);
        int span;
        span = 1;
        for (int k = 0; k < LEVELS - lvl; k++) begin
            span = span * MAX_FANOUT;
        end
        return (NUM_OUT + span - 1) / span;
    endfunction

    // Index of the first node of level lvl in the flat node array.
    function automatic int level_base(input int lvl);
        int b;
        b = 0;
        for (int k = 1; k < lvl; k++) begin
            b = b + nodes_at(k);
        end
        return b;
    endfunction

    localparam int TOTAL = level_base(LEVELS + 1);

    logic [WIDTH-1:0]  node_q [TOTAL];
    logic [WIDTH-1:0]  node_d [TOTAL];
    logic [LEVELS-1:0] v_q;      // v_q[l-1] is the valid bit of level l
    logic [LEVELS:0]   vin;      // vin[l] is v_l, with vin[0] = in_valid

    assign vin = {v_q, in_valid};

    // Next value of every node: load from its parent when the level above
    // held a word, otherwise keep the old value (bubbles do not disturb data).
    for (genvar l = 1; l <= LEVELS; l++) begin : g_lvl
        for (genvar j = 0; j < nodes_at(l); j++) begin : g_node
            localparam int IDX = level_base(l) + j;
            logic [WIDTH-1:0] src;

            if (l == 1) begin : g_root
                assign src = in_data;
            end else begin : g_inner
                assign src = node_q[level_base(l - 1) + j / MAX_FANOUT];
            end

            if (l == LEVELS) begin : g_leaf
                assign node_d[IDX] = (vin[l-1] && chan_en[j])
                                   ? (INV_MASK[j] ? ~src : src)
                                   : node_q[IDX];
            end else begin : g_mid
                assign node_d[IDX] = vin[l-1] ? src : node_q[IDX];
            end
        end
    end

    // Tree registers and valid chain; reset wins over stall, stall freezes all.
    always_ff @(posedge clk) begin
        if (rst) begin
            v_q <= '0;
            for (int i = 0; i < TOTAL; i++) begin
                node_q[i] <= '0;
            end
        end else if (!stall) begin
            v_q <= vin[LEVELS-1:0];
            for (int i = 0; i < TOTAL; i++) begin
                node_q[i] <= node_d[i];
            end
        end
    end

    for (genvar c = 0; c < NUM_OUT; c++) begin : g_out
        assign out_data[c*WIDTH +: WIDTH] = node_q[level_base(LEVELS) + c];
    end

    assign out_valid = v_q[LEVELS-1];
    assign busy      = |v_q;

endmodule
